// File: rtl/p5_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM.
// One access per cycle; read data returns to the requester two edges after acceptance.
module p5_mem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_data_in,
    output logic          ram_we,
    input  logic [DW-1:0] ram_data_out
);

    logic          prio_q, prio_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          s1_valid_q, s1_port_q, s1_read_q;
    logic          s1_port_d, s1_read_d;
    logic          s2_valid_q, s2_port_q, s2_read_q;
    logic          accept, sel;

    // Grants are held low during reset so nothing can be accepted while rst_n is low.
    assign gnt0   = rst_n & req0 & (~req1 | ~prio_q);
    assign gnt1   = rst_n & req1 & (~req0 |  prio_q);
    assign accept = gnt0 | gnt1;
    assign sel    = gnt1;

    always_comb begin
        prio_d    = accept ? ~sel : prio_q;
        addr_d    = accept ? (sel ? addr1  : addr0)  : addr_q;
        wdata_d   = accept ? (sel ? wdata1 : wdata0) : wdata_q;
        we_d      = accept & (sel ? we1 : we0);
        s1_port_d = accept ? sel : s1_port_q;
        s1_read_d = accept ? ~(sel ? we1 : we0) : s1_read_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_port_q  <= 1'b0;
            s1_read_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_port_q  <= 1'b0;
            s2_read_q  <= 1'b0;
        end else begin
            prio_q     <= prio_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            s1_valid_q <= accept;
            s1_port_q  <= s1_port_d;
            s1_read_q  <= s1_read_d;
            s2_valid_q <= s1_valid_q;
            s2_port_q  <= s1_port_q;
            s2_read_q  <= s1_read_q;
        end
    end

    assign ram_address = addr_q;
    assign ram_data_in = wdata_q;
    assign ram_we      = we_q;

    // RAM output is already registered, so read data is shared and qualified only by rvalid.
    assign rvalid0 = s2_valid_q & s2_read_q & ~s2_port_q;
    assign rvalid1 = s2_valid_q & s2_read_q &  s2_port_q;
    assign rdata0  = ram_data_out;
    assign rdata1  = ram_data_out;

endmodule

// File: doc/p5_mem_arbiter.md
# p5_mem_arbiter

Two-port round-robin arbiter that shares the single-port 256x16 synchronous data RAM between the CPU datapath (port 0) and the I/O block (port 1). It accepts at most one access per cycle using a req/gnt handshake, drives registered address/data/write-enable into the RAM, and routes read data back to the requester with a fixed 2-cycle latency. It sits between the processor core, the I/O controller and the RAM instance.

## Interface
- `AW`, 8: RAM address width (256 locations).
- `DW`, 16: RAM data width.
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0` / `req1`  in  1  access request from port 0 / port 1.
- `we0` / `we1`  in  1  1 = write, 0 = read; held with req.
- `addr0` / `addr1`  in  AW  access address; held with req.
- `wdata0` / `wdata1`  in  DW  write data; held with req.
- `gnt0` / `gnt1`  out  1  combinational grant; request accepted at the clock edge where req&gnt are high.
- `rvalid0` / `rvalid1`  out  1  read data valid for that port, one-cycle pulse.
- `rdata0` / `rdata1`  out  DW  read data, meaningful only while matching rvalid is high.
- `ram_address`  out  AW  registered RAM address.
- `ram_data_in`  out  DW  registered RAM write data.
- `ram_we`  out  1  registered RAM write enable.
- `ram_data_out`  in  DW  RAM read data (RAM registers it one edge after address).

## Operation
- Priority pointer `prio` (1 bit) names the favoured port; reset value 0.
- Grant: only req0 -> gnt0; only req1 -> gnt1; both -> gnt of `prio`; neither -> no grant. At most one gnt high. gnt0=gnt1=0 while rst_n=0.
- On an accepted access: `prio` <= index of the port NOT granted. No acceptance -> `prio` unchanged.
- Stage 1 (acceptance edge): ram_address/ram_data_in <= granted port's addr/wdata; ram_we <= granted we; s1_valid <= 1, s1_port, s1_read <= ~we.
- No acceptance: ram_we <= 0, s1_valid <= 0; ram_address and ram_data_in hold.
- Stage 2 (next edge): s2_valid/s2_port/s2_read <= stage 1 fields.
- Response: rvalidN = s2_valid & s2_read & (s2_port==N); rdataN = ram_data_out for both ports (gated only by rvalid).
- Writes produce no response; requester may treat gnt as completion.
- Requester must hold req/we/addr/wdata stable until granted; may drop req only after the accepting edge; may re-assert in the next cycle.

## Timing
- Throughput: one access per cycle, continuous back-to-back from either or both ports.
- Read accepted at edge E0 -> RAM sees address during cycle E0..E1 -> rvalid high during cycle after E1 (2 cycles after E0 edge, sampled at E2).
- Write accepted at E0 -> RAM written at E1.
- Write at E0 then read same address at E1 (either port) -> read returns new data.
- Both ports requesting continuously -> strict alternation 0,1,0,1... starting with `prio`.
- Reset values: ram_address=0, ram_data_in=0, ram_we=0, rvalid0=rvalid1=0, gnt0=gnt1=0, all stage valids 0, prio=0.
- Reset asserted mid-operation: all in-flight accesses discarded immediately (async); no rvalid emitted for them; ram_we deasserts at once so no write occurs at the next edge.
- After rst_n release, first grant possible in the first cycle; port 0 wins a tie.

## Test plan
- Reset: drive rst_n=0 with req0=req1=1 -> gnt0=gnt1=0, ram_we=0, rvalid=0, ram_address=0; release -> gnt0=1 first cycle.
- Single-port write/read: port0 writes 0xBEEF to 0x12, then reads 0x12 next cycle -> rvalid0 exactly 2 cycles after read acceptance, rdata0=0xBEEF, rvalid1 never high.
- Contention: req0=req1=1 continuously reading 0x01/0x02 (preloaded 0x0001/0x0002) for 6 cycles -> grants 0,1,0,1,0,1; rvalid alternates with rdata 0x0001/0x0002.
- Cross-port coherence: port1 writes 0x55AA to 0xFF at E0, port0 reads 0xFF at E1 -> rdata0=0x55AA at cycle after E2.
- Idle gap: single read then no requests -> ram_we=0, no extra rvalid; prio toggled only once.
- Reset mid-read: accept read at E0, assert rst_n=0 before E1 -> no rvalid at any later cycle; RAM contents unchanged.
